sram_fifo_ctrl: RTL



---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ram.sv | 38 +++
 rtl/sram_fifo_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for sram_fifo_ctrl and fifo_ram.
//   - default parameter values of the FIFO
//   - clog2() for pointer sizing
//   - derived count width (pointer width + 1, so the count can reach DEPTH)
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH    = 12;
   localparam int unsigned DEF_DEPTH         = 8;
   localparam int unsigned DEF_AEMPTY_THRESH = 2;
   localparam int unsigned DEF_AFULL_THRESH  = DEF_DEPTH - 2;
   localparam int unsigned DEF_FWFT          = 0;

   // Smallest r with 2**r >= n; n is expected to be >= 2
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Count must represent 0..DEPTH inclusive
   function automatic int unsigned count_width(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

   localparam int unsigned DEF_ADDR_WIDTH  = clog2(DEF_DEPTH);
   localparam int unsigned DEF_COUNT_WIDTH = DEF_ADDR_WIDTH + 1;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port
   assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// Single-clock FIFO around fifo_ram with occupancy count, registered status
// flags, overflow/underflow pulses and an optional first-word-fall-through
// output stage.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   wr_en / din   in   write request and data
//   rd_en         in   read request (FWFT: pop the word shown on dout)
//   dout          out  read data
//   dout_valid    out  dout holds valid data
//   count         out  stored words, 0..DEPTH
//   full, empty, almost_full, almost_empty  out  registered status flags
//   overflow      out  one-cycle pulse per rejected write
//   underflow     out  one-cycle pulse per rejected read
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH         = DEF_DEPTH,
   parameter int unsigned ADDR_WIDTH    = clog2(DEPTH),
   parameter int unsigned AFULL_THRESH  = DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH,
   parameter int unsigned FWFT          = DEF_FWFT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;
   logic                  full_q,   full_d;
   logic                  empty_q,  empty_d;
   logic                  afull_q,  afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q,    ovf_d;
   logic                  udf_q,    udf_d;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Pointer increment with explicit wrap at DEPTH-1 (DEPTH need not be 2**N)
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   // Acceptance, pointer/count next state and flags from the next count
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      rd_acc = rd_en && !empty_q;
      // At full a same-cycle accepted read frees the slot being written
      wr_acc = wr_en && (!full_q || rd_acc);

      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);

      count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      full_d   = (count_d == CNT_W'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CNT_W'(AFULL_THRESH));
      aempty_d = (count_d <= CNT_W'(AEMPTY_THRESH));

      ovf_d = wr_en && !wr_acc;
      udf_d = rd_en && !rd_acc;
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Output stage: fall-through head or registered read data
   if (FWFT != 0) begin : g_fwft
      // Gate with empty so dout reads 0 after reset rather than stale memory
      assign dout       = empty_q ? '0 : ram_rdata;
      assign dout_valid = !empty_q;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  valid_q, valid_d;

      always_comb begin
         dout_d  = dout_q;
         valid_d = rd_acc;
         if (rd_acc) dout_d = ram_rdata;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
         end
      end

      assign dout       = dout_q;
      assign dout_valid = valid_q;
   end

   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule : sram_fifo_ctrl
